snn_frame_loader: RTL and testbench
===================================

Name: snn_frame_loader

Overview:
- Writer side of the 784x1 input-unit RAM that the SNN core reads.
- Accepts serial-received bytes and unpacks each one LSB-first into 8 consecutive 1-bit RAM writes; 98 bytes make one 784-pixel frame.
- After the frame is written: pulses the core's start, waits for done, latches the 4-bit digit, and sends it as one ASCII character to the UART transmitter.
- Sits between uart_rx/uart_tx and snn_core at the top level. The top level muxes the RAM address using `core_phase`.

Parameters:
- NUM_BITS, 784, pixels per frame (must be a multiple of 8).
- ADDR_W, 10, input RAM address width.
- ASCII_BASE, 8'h30, added to the digit to form the TX character.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort: return to RX_WAIT with the address at 0
- rx_rdy  in  1  single-cycle strobe: rx_data is valid
- rx_data  in  8  received byte
- ram_we  out  1  input RAM write enable
- ram_addr  out  ADDR_W  input RAM write address
- ram_d  out  1  input RAM write data (pixel bit)
- core_phase  out  1  high while the core owns the RAM (START, WAIT_DONE)
- snn_start  out  1  single-cycle start pulse to the core
- snn_done  in  1  core completion strobe
- snn_digit  in  4  core result, valid while snn_done=1
- tx_busy  in  1  transmitter busy
- tx_start  out  1  single-cycle transmit request
- tx_data  out  8  ASCII digit
- digit  out  4  last classified digit, held
- ovr  out  1  single-cycle pulse: a byte was dropped

Behaviour:
- Reset values: all outputs 0; state RX_WAIT; write address 0; shift register 0; bit counter 0.
- States: RX_WAIT, WRITE, START, WAIT_DONE, TX_REQ.
- RX_WAIT
  - On rx_rdy: load rx_data into an 8-bit shift register, clear the bit counter, go to WRITE.
- WRITE (exactly 8 cycles)
  - Each cycle: ram_we=1, ram_d=shift[0], ram_addr=waddr.
  - Then shift right and increment both waddr and the bit counter.
  - Byte k bit i therefore lands at address 8k+i, written on the (i+1)th cycle after the capture edge.
  - When bit counter=7: if waddr=NUM_BITS-1, go to START and clear waddr to 0; otherwise go to RX_WAIT.
- START
  - snn_start=1 for one cycle; core_phase=1; go to WAIT_DONE.
  - The first snn_start comes 1 cycle after the final write of the frame.
- WAIT_DONE
  - core_phase=1; hold until snn_done.
  - On snn_done: digit<=snn_digit; tx_data<=ASCII_BASE+snn_digit (8-bit add, zero-extended digit); go to TX_REQ.
- TX_REQ
  - If !tx_busy: tx_start=1 for one cycle, then go to RX_WAIT.
  - Otherwise wait; no timeout.
  - tx_data and digit hold until the next snn_done.
- Dropped bytes: rx_rdy in any state other than RX_WAIT discards the byte and pulses ovr the next cycle. waddr is unchanged, so a frame with dropped bytes is misaligned until clr.
- snn_done outside WAIT_DONE: ignored.
- clr: highest priority after reset. Next state is RX_WAIT; waddr, bit counter and shift register are cleared. Any write, start or transmit in progress is abandoned. digit and tx_data are kept.
- rx_rdy and clr in the same cycle: clr wins, and the byte is dropped without ovr.
- Asynchronous reset mid-frame behaves like clr, and also resets digit/tx_data to 0.
- Address bounds: waddr never exceeds NUM_BITS-1. Wrap-around happens only via the START transition.
- Throughput: 9 cycles per byte minimum (1 cycle in RX_WAIT + 8 cycles in WRITE). A back-to-back rx_rdy on the cycle after capture is dropped.

Decomposition:
- Package snn_pkg holds:
  - NUM_INPUT=784, ASCII_ZERO=8'h30;
  - loader_state_t enum {RX_WAIT, WRITE, START, WAIT_DONE, TX_REQ}, 3 bits wide;
  - INPUT_ADDR_W=10.
- One sub-module is natural: byte_unpacker. It holds the shift register, the bit counter and the waddr counter, with inputs load/clr_addr and outputs ram_we/ram_d/ram_addr/byte_done/frame_done. The FSM stays in the top.

Test Plan:
- Reset, then send 98 bytes of 8'hA5 -> RAM address 0..7 read 1,0,1,0,0,1,0,1 and the pattern repeats to address 783. Exactly 784 ram_we cycles. snn_start pulses once, 1 cycle after the write to address 783.
- Full frame, then the model drives snn_done with snn_digit=4'd7, tx_busy=0 -> digit=7, tx_data=8'h37, tx_start pulses once the cycle after done, and the state returns to RX_WAIT with waddr=0.
- Hold tx_busy=1 for 20 cycles after done (digit 3) -> tx_start stays low, tx_data=8'h33 holds, and tx_start pulses on the first cycle tx_busy=0.
- rx_rdy on the cycle after the first capture, and again during WAIT_DONE -> each byte is dropped, ovr pulses once per drop, and the waddr progression is unaffected.
- clr asserted after 50 bytes -> waddr=0. The next 98 bytes form a full frame starting at address 0, and snn_start fires only after those 98.
- Assert rst_n low during WRITE of byte 10, then release -> all outputs 0 and the state is RX_WAIT; a following 98-byte frame completes normally. Also drive snn_done in RX_WAIT and confirm no effect.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input-frame loader.
package snn_pkg;

  localparam int         NUM_INPUT    = 784;
  localparam int         INPUT_ADDR_W = 10;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  typedef enum logic [2:0] {
    RX_WAIT   = 3'd0,
    WRITE     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    TX_REQ    = 3'd4
  } loader_state_t;

  // Converts a 4-bit class index to its printable character.
  function automatic logic [7:0] digit_to_ascii(input logic [7:0] base,
                                                input logic [3:0] d);
    return base + {4'b0000, d};
  endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Serialises one captured byte LSB-first into consecutive 1-bit RAM writes
// and tracks the frame write address.
module byte_unpacker
  import snn_pkg::*;
#(
  parameter int NUM_BITS = NUM_INPUT,
  parameter int ADDR_W   = INPUT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_addr,
  input  logic              load,
  input  logic [7:0]        load_data,
  input  logic              wr_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              byte_done,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);

  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;

  assign ram_we     = wr_en;
  assign ram_addr   = waddr_q;
  assign ram_d      = shift_q[0];
  assign byte_done  = wr_en && (bit_cnt_q == 3'd7);
  assign frame_done = byte_done && (waddr_q == LAST_ADDR);

  // Next-state for shift register, bit counter and address; the address
  // only wraps to 0 on the final bit of a frame.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    waddr_d   = waddr_q;
    if (clr_addr) begin
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
      waddr_d   = '0;
    end else if (load) begin
      shift_d   = load_data;
      bit_cnt_d = 3'd0;
    end else if (wr_en) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      waddr_d   = frame_done ? '0 : waddr_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      waddr_q   <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      waddr_q   <= waddr_d;
    end
  end

endmodule

// File: rtl/snn_frame_loader.sv
// Writer side of the SNN input-unit RAM: unpacks received bytes into pixels,
// kicks the core once a frame is complete and forwards the result to the UART.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   RX_WAIT   | idle, waiting for the next received byte
//   WRITE     | 8 cycles writing the captured byte, one bit per cycle
//   START     | one-cycle start pulse to the core (core owns the RAM)
//   WAIT_DONE | core running, waiting for its done strobe
//   TX_REQ    | waiting for the transmitter to accept the ASCII digit
module snn_frame_loader
  import snn_pkg::*;
#(
  parameter int         NUM_BITS   = NUM_INPUT,
  parameter int         ADDR_W     = INPUT_ADDR_W,
  parameter logic [7:0] ASCII_BASE = ASCII_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              core_phase,
  output logic              snn_start,
  input  logic              snn_done,
  input  logic [3:0]        snn_digit,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        digit,
  output logic              ovr
);

  loader_state_t state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ovr_q, ovr_d;

  logic load;
  logic wr_en;
  logic byte_done;
  logic frame_done;

  byte_unpacker #(
    .NUM_BITS (NUM_BITS),
    .ADDR_W   (ADDR_W)
  ) u_unpacker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_addr   (clr),
    .load       (load),
    .load_data  (rx_data),
    .wr_en      (wr_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .byte_done  (byte_done),
    .frame_done (frame_done)
  );

  assign digit   = digit_q;
  assign tx_data = tx_data_q;
  assign ovr     = ovr_q;

  // Next-state and strobes; clr abandons everything but keeps the last result.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    tx_data_d  = tx_data_q;
    ovr_d      = 1'b0;
    load       = 1'b0;
    wr_en      = 1'b0;
    snn_start  = 1'b0;
    core_phase = 1'b0;
    tx_start   = 1'b0;
    if (clr) begin
      state_d = RX_WAIT;
    end else begin
      // Only RX_WAIT can accept a byte; anything else is dropped and flagged.
      ovr_d = rx_rdy && (state_q != RX_WAIT);
      unique case (state_q)
        RX_WAIT: begin
          if (rx_rdy) begin
            load    = 1'b1;
            state_d = WRITE;
          end
        end
        WRITE: begin
          wr_en = 1'b1;
          if (byte_done) begin
            state_d = frame_done ? START : RX_WAIT;
          end
        end
        START: begin
          snn_start  = 1'b1;
          core_phase = 1'b1;
          state_d    = WAIT_DONE;
        end
        WAIT_DONE: begin
          core_phase = 1'b1;
          if (snn_done) begin
            digit_d   = snn_digit;
            tx_data_d = digit_to_ascii(ASCII_BASE, snn_digit);
            state_d   = TX_REQ;
          end
        end
        TX_REQ: begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            state_d  = RX_WAIT;
          end
        end
        default: state_d = RX_WAIT;
      endcase
    end
  end

  // State, result and overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_WAIT;
      digit_q   <= 4'd0;
      tx_data_q <= 8'h00;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed bench for snn_frame_loader.
module tb_snn_frame_loader;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       snn_done = 1'b0;
  logic [3:0] snn_digit = 4'd0;
  logic       tx_busy = 1'b0;

  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       core_phase;
  logic       snn_start;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] digit;
  logic       ovr;

  snn_frame_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .core_phase (core_phase),
    .snn_start  (snn_start),
    .snn_done   (snn_done),
    .snn_digit  (snn_digit),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .digit      (digit),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int   cyc = 0;
  logic mem [0:NPIX-1];
  int   we_cnt = 0, start_cnt = 0, tx_cnt = 0, ovr_cnt = 0;
  int   last_we_cyc = 0, start_cyc = 0;
  logic fill_req = 1'b0, fill_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (fill_req) for (int a = 0; a < NPIX; a++) mem[a] = fill_val;
    if (ram_we) begin
      if (32'(ram_addr) < NPIX) mem[ram_addr] = ram_d;
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (snn_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (tx_start) tx_cnt++;
    if (ovr) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    repeat (7) tick();
  endtask

  task automatic send_frame(input logic [7:0] b);
    repeat (98) send_byte(b);
  endtask

  task automatic done_pulse(input logic [3:0] d);
    snn_digit = d;
    snn_done  = 1'b1;
    tick();
    snn_done  = 1'b0;
  endtask

  task automatic fill(input logic v);
    fill_val = v;
    fill_req = 1'b1;
    @(negedge clk);
    #1 fill_req = 1'b0;
  endtask

  // Byte 0 of the frame is 'first', every other byte is 'rest'.
  task automatic check_mem(input string tag, input logic [7:0] first, input logic [7:0] rest);
    int bad;
    logic [7:0] b;
    bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      b = (a < 8) ? first : rest;
      if (mem[a] !== b[3'(a % 8)]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({ram_we, ram_addr, ram_d, core_phase, snn_start, tx_start, tx_data, digit, ovr});
  endfunction

  int w0, s0, t0, o0, w1, bad;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;
    tick();

    // Full frame of 0xA5
    fill(1'b0);
    w0 = we_cnt; s0 = start_cnt; t0 = tx_cnt;
    send_frame(8'hA5);
    repeat (2) tick();
    chk("s1_we_cnt", we_cnt - w0, 784);
    chk("s1_start_cnt", start_cnt - s0, 1);
    chk("s1_start_lat", start_cyc - last_we_cyc, 1);
    check_mem("s1_pattern", 8'hA5, 8'hA5);
    chk("s1_core_phase", 32'(core_phase), 1);
    chk("s1_waddr_wrap", 32'(ram_addr), 0);

    // Result 7, transmitter idle
    done_pulse(4'd7);
    chk("s2_tx_start", 32'(tx_start), 1);
    chk("s2_digit", 32'(digit), 7);
    chk("s2_tx_data", 32'(tx_data), 32'h37);
    tick();
    chk("s2_tx_cnt", tx_cnt - t0, 1);
    chk("s2_core_phase", 32'(core_phase), 0);
    chk("s2_waddr", 32'(ram_addr), 0);

    // Result 3 with transmitter busy for 20 cycles
    fill(1'b1);
    w0 = we_cnt; s0 = start_cnt; t0 = tx_cnt;
    send_frame(8'h5A);
    repeat (2) tick();
    chk("s3_start_cnt", start_cnt - s0, 1);
    check_mem("s3_pattern", 8'h5A, 8'h5A);
    tx_busy = 1'b1;
    done_pulse(4'd3);
    bad = 0;
    repeat (20) begin
      if (tx_start !== 1'b0) bad++;
      if (tx_data !== 8'h33) bad++;
      tick();
    end
    chk("s3_busy_hold", bad, 0);
    chk("s3_tx_cnt_busy", tx_cnt - t0, 0);
    tx_busy = 1'b0;
    #1;
    chk("s3_tx_start", 32'(tx_start), 1);
    tick();
    chk("s3_tx_cnt", tx_cnt - t0, 1);
    chk("s3_tx_data", 32'(tx_data), 32'h33);
    chk("s3_digit", 32'(digit), 3);

    // Dropped bytes: back-to-back after capture, and during WAIT_DONE
    fill(1'b1);
    w0 = we_cnt; s0 = start_cnt; o0 = ovr_cnt;
    tick();
    rx_rdy  = 1'b1;
    rx_data = 8'h0F;
    tick();
    rx_data = 8'hF0;
    tick();
    rx_rdy  = 1'b0;
    chk("s4_ovr_pulse", 32'(ovr), 1);
    repeat (6) tick();
    repeat (97) send_byte(8'h00);
    repeat (2) tick();
    chk("s4_start_cnt", start_cnt - s0, 1);
    chk("s4_we_cnt", we_cnt - w0, 784);
    check_mem("s4_pattern", 8'h0F, 8'h00);
    rx_rdy  = 1'b1;
    rx_data = 8'hFF;
    tick();
    rx_rdy  = 1'b0;
    chk("s4_ovr_wait_done", 32'(ovr), 1);
    tick();
    chk("s4_ovr_single", 32'(ovr), 0);
    chk("s4_ovr_cnt", ovr_cnt - o0, 2);
    chk("s4_no_write", we_cnt - w0, 784);
    done_pulse(4'd1);
    tick();

    // clr after 50 bytes, then clr together with rx_rdy
    w0 = we_cnt; s0 = start_cnt; o0 = ovr_cnt;
    repeat (50) send_byte(8'hFF);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s5_waddr_clr", 32'(ram_addr), 0);
    chk("s5_digit_kept", 32'(digit), 1);
    tick();
    rx_rdy  = 1'b1;
    rx_data = 8'hFF;
    clr     = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    clr     = 1'b0;
    tick();
    chk("s5_clr_rx_ovr", ovr_cnt - o0, 0);
    chk("s5_clr_rx_we", we_cnt - w0, 400);
    fill(1'b1);
    w1 = we_cnt;
    repeat (97) send_byte(8'h00);
    repeat (2) tick();
    chk("s5_no_early_start", start_cnt - s0, 0);
    send_byte(8'h00);
    repeat (2) tick();
    chk("s5_start_cnt", start_cnt - s0, 1);
    chk("s5_we_cnt", we_cnt - w1, 784);
    check_mem("s5_pattern", 8'h00, 8'h00);
    done_pulse(4'd9);
    tick();
    chk("s5_tx_data", 32'(tx_data), 32'h39);

    // Async reset while writing byte 10, stray done in RX_WAIT, then a frame
    t0 = tx_cnt;
    repeat (10) send_byte(8'h33);
    tick();
    rx_rdy  = 1'b1;
    rx_data = 8'hC3;
    tick();
    rx_rdy  = 1'b0;
    repeat (2) tick();
    chk("s6_in_write", 32'(ram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outs", outs_vec(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    t0 = tx_cnt;
    done_pulse(4'd5);
    tick();
    chk("s6_stray_digit", 32'(digit), 0);
    chk("s6_stray_tx", tx_cnt - t0, 0);
    chk("s6_stray_phase", 32'(core_phase), 0);
    fill(1'b0);
    w0 = we_cnt; s0 = start_cnt;
    send_frame(8'hA5);
    repeat (2) tick();
    chk("s6_start_cnt", start_cnt - s0, 1);
    chk("s6_we_cnt", we_cnt - w0, 784);
    check_mem("s6_pattern", 8'hA5, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
